// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// configuration bundle and round-robin pointer reset value.
package uart_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int BAUD_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [BAUD_W-1:0] baud;
        logic              eight;
        logic              pen;
        logic              ohel;
    } uart_cfg_t;

    // 0 gives req0 priority when both requesters collide.
    localparam logic RR_PTR_RST = 1'b0;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// Two-requester round-robin winner select; the priority pointer moves only
// when the scheduler reports a served (acked) requester.
module rr_arbiter2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    input  logic i_served1,
    output logic o_valid,
    output logic o_sel
);

    logic r_prio1;

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_sel   = i_req1 & (~i_req0 | r_prio1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_prio1 <= RR_PTR_RST;
        else if (i_upd)
            r_prio1 <= ~i_served1;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX engine between the echo (req0) and message (req1) paths,
// and applies config only while idle. Optional ack/timeout statistics are
// enabled by defining UART_TX_SCHED_STATS_EN.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              tx_ready,
    output logic              tx_write,
    output logic [DATA_W-1:0] tx_data,
    input  logic [BAUD_W-1:0] cfg_baud,
    input  logic              cfg_eight,
    input  logic              cfg_pen,
    input  logic              cfg_ohel,
    output logic [BAUD_W-1:0] baud,
    output logic              eight,
    output logic              pen,
    output logic              ohel,
    output logic              busy,
    output logic              timeout_err
`ifdef UART_TX_SCHED_STATS_EN
   ,output logic [15:0]       cnt0,
    output logic [15:0]       cnt1,
    output logic [7:0]        to_cnt
`endif
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    tx_state_t         r_state;
    uart_cfg_t         r_cfg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tx_write, r_ack0, r_ack1, r_busy, r_timeout_err;
    logic [DATA_W-1:0] r_tx_data;

    uart_cfg_t w_cfg_req;
    logic      w_cfg_diff, w_grant_valid, w_grant_sel, w_timeout;

    assign w_cfg_req  = {cfg_baud, cfg_eight, cfg_pen, cfg_ohel};
    assign w_cfg_diff = (w_cfg_req != r_cfg);
    assign w_timeout  = (r_state == S_WAIT_BUSY) && tx_ready && (r_cnt == TO_LAST);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_upd     (r_ack0 | r_ack1),
        .i_served1 (r_ack1),
        .o_valid   (w_grant_valid),
        .o_sel     (w_grant_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tx_write    <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tx_data     <= '0;
            r_cnt         <= '0;
            r_cfg         <= w_cfg_req;
        end else begin
            // NOTE: strobes default low each cycle so they stay single-cycle pulses.
            r_tx_write <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_diff) begin
                        r_cfg <= w_cfg_req;
                    end else if (tx_ready && w_grant_valid) begin
                        r_state    <= S_LOAD;
                        r_busy     <= 1'b1;
                        r_tx_write <= 1'b1;
                        r_tx_data  <= w_grant_sel ? data1 : data0;
                        r_ack0     <= ~w_grant_sel;
                        r_ack1     <= w_grant_sel;
                    end
                end
                S_LOAD: begin
                    r_state <= S_WAIT_BUSY;
                    r_cnt   <= '0;
                end
                S_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_ready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_write    = r_tx_write;
    assign tx_data     = r_tx_data;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign baud        = r_cfg.baud;
    assign eight       = r_cfg.eight;
    assign pen         = r_cfg.pen;
    assign ohel        = r_cfg.ohel;

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] r_cnt0, r_cnt1;
    logic [7:0]  r_to_cnt;

    // Ack counters wrap naturally; the timeout counter saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt0   <= '0;
            r_cnt1   <= '0;
            r_to_cnt <= '0;
        end else begin
            if (r_ack0) r_cnt0 <= r_cnt0 + 16'd1;
            if (r_ack1) r_cnt1 <= r_cnt1 + 16'd1;
            if (w_timeout && (r_to_cnt != 8'hFF)) r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign cnt0   = r_cnt0;
    assign cnt1   = r_cnt1;
    assign to_cnt = r_to_cnt;
`endif

endmodule
